// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle controller for the ARM-subset core: FETCH/DECODE/EXEC/MEM/WB/BRANCH/MULX/FAULT.
// Optional multi-cycle multiply is compiled in when CTRL_MUL_EN is defined.
module mc_ctrl_fsm #(
    parameter int STATE_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int MUL_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               N,
    input  logic               Z,
    input  logic               C,
    input  logic               V,
    input  logic               dm_ready,
    output logic               PCwr,
    output logic               DMwr,
    output logic               dm_req,
    output logic               RFwr,
    output logic               flag_wr,
    output logic [3:0]         ALUop,
    output logic [1:0]         EXTop,
    output logic [1:0]         NPCop,
    output logic [1:0]         Rw,
    output logic               RbSrc,
    output logic               ALUBSrc,
    output logic               PCtoBL,
    output logic               IMen,
    output logic               fault,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_MULX   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam int MUL_W  = $clog2(MUL_CYCLES) + 1;

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [MUL_W-1:0]  mul_q, mul_d;
    logic              fault_q, fault_d;

    logic [3:0] cond;
    logic       cond_pass;
    logic       is_mem;
    logic       is_branch;
    logic       is_cmp;
    logic       is_mul_enc;
    logic       mul_ok;
    logic       undef_enc;
    logic       wait_last;
    logic       mul_last;
    logic       unused_ir_bits;

    assign cond       = ir_q[31:28];
    assign is_mem     = (ir_q[27:26] == 2'b01);
    assign is_branch  = (ir_q[27:25] == 3'b101);
    assign is_cmp     = (ir_q[24:23] == 2'b10);
    assign is_mul_enc = (ir_q[27:22] == 6'b000000) && (ir_q[7:4] == 4'b1001);
    assign wait_last  = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign mul_last   = (mul_q == MUL_W'(MUL_CYCLES - 1));
    // Register fields and the immediate are consumed by the datapath, not here.
    assign unused_ir_bits = ^{ir_q[19:8], ir_q[3:0]};

`ifdef CTRL_MUL_EN
    assign mul_ok = is_mul_enc;
`else
    assign mul_ok = 1'b0;
`endif

    // Without the multiplier a MUL encoding is just another undefined instruction.
    assign undef_enc = (ir_q[27:26] == 2'b11) ||
                       (ir_q[27:25] == 3'b100) ||
                       (is_mem && ir_q[25]) ||
                       (is_mul_enc && !mul_ok);

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = Z;
            4'b0001: cond_pass = !Z;
            4'b0010: cond_pass = C;
            4'b0011: cond_pass = !C;
            4'b0100: cond_pass = N;
            4'b0101: cond_pass = !N;
            4'b0110: cond_pass = V;
            4'b0111: cond_pass = !V;
            4'b1000: cond_pass = C && !Z;
            4'b1001: cond_pass = !C || Z;
            4'b1010: cond_pass = (N == V);
            4'b1011: cond_pass = (N != V);
            4'b1100: cond_pass = !Z && (N == V);
            4'b1101: cond_pass = Z || (N != V);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            wait_q  <= '0;
            mul_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            mul_q   <= mul_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = '0;
        mul_d   = '0;
        fault_d = fault_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cond == 4'b1111)  state_d = S_FAULT;
                else if (!cond_pass)  state_d = S_FETCH;
                else if (undef_enc)   state_d = S_FAULT;
                else if (is_branch)   state_d = S_BRANCH;
                else                  state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_mem)       state_d = S_MEM;
                else if (mul_ok)  state_d = S_MULX;
                else if (is_cmp)  state_d = S_FETCH;
                else              state_d = S_WB;
            end
            S_MEM: begin
                // A completion in the timeout cycle still wins over the fault.
                if (dm_ready)       state_d = ir_q[20] ? S_WB : S_FETCH;
                else if (wait_last) state_d = S_FAULT;
                else                wait_d  = wait_q + WAIT_W'(1);
            end
            S_MULX: begin
                if (mul_last) state_d = S_WB;
                else          mul_d   = mul_q + MUL_W'(1);
            end
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
        if (state_d == S_FAULT) fault_d = 1'b1;
    end

    always_comb begin
        PCwr    = 1'b0;
        DMwr    = 1'b0;
        dm_req  = 1'b0;
        RFwr    = 1'b0;
        flag_wr = 1'b0;
        ALUop   = 4'b0000;
        EXTop   = 2'b00;
        NPCop   = 2'b00;
        Rw      = 2'b00;
        RbSrc   = 1'b0;
        ALUBSrc = 1'b0;
        PCtoBL  = 1'b0;
        IMen    = 1'b0;
        fault   = fault_q && !rst;
        State   = rst ? '0 : STATE_W'(state_q);
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    IMen = 1'b1;
                    PCwr = 1'b1;
                end
                S_EXEC: begin
                    if (is_mem) begin
                        ALUop   = ir_q[23] ? 4'b0100 : 4'b0010;
                        ALUBSrc = 1'b1;
                        RbSrc   = 1'b1;
                    end else begin
                        ALUop   = ir_q[24:21];
                        ALUBSrc = ir_q[25];
                        EXTop   = 2'b01;
                        // A multiply updates flags only once its result is final.
                        flag_wr = mul_ok ? 1'b0 : (is_cmp || ir_q[20]);
                    end
                end
                S_MEM: begin
                    dm_req = 1'b1;
                    DMwr   = !ir_q[20];
                end
                S_WB: begin
                    RFwr = 1'b1;
                    Rw   = mul_ok ? 2'b10 : 2'b00;
                end
                S_BRANCH: begin
                    PCwr  = 1'b1;
                    NPCop = 2'b01;
                    EXTop = 2'b10;
                    if (ir_q[24]) begin
                        RFwr   = 1'b1;
                        Rw     = 2'b01;
                        PCtoBL = 1'b1;
                    end
                end
                S_MULX: flag_wr = mul_last && ir_q[20];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected output vectors are queued, then
// popped and compared one per clock while the instruction runs.
module tb_mc_ctrl_fsm;
    localparam int STATE_W     = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int MUL_CYCLES  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
    logic        dm_ready = 1'b0;

    logic               PCwr, DMwr, dm_req, RFwr, flag_wr;
    logic [3:0]         ALUop;
    logic [1:0]         EXTop, NPCop, Rw;
    logic               RbSrc, ALUBSrc, PCtoBL, IMen, fault;
    logic [STATE_W-1:0] State;

    mc_ctrl_fsm #(
        .STATE_W(STATE_W), .MEM_TIMEOUT(MEM_TIMEOUT), .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .N(N), .Z(Z), .C(C), .V(V), .dm_ready(dm_ready),
        .PCwr(PCwr), .DMwr(DMwr), .dm_req(dm_req), .RFwr(RFwr), .flag_wr(flag_wr),
        .ALUop(ALUop), .EXTop(EXTop), .NPCop(NPCop), .Rw(Rw),
        .RbSrc(RbSrc), .ALUBSrc(ALUBSrc), .PCtoBL(PCtoBL), .IMen(IMen),
        .fault(fault), .State(State)
    );

    always #5 clk = ~clk;

    // {State, PCwr, DMwr, dm_req, RFwr, flag_wr, ALUop, EXTop, NPCop, Rw, RbSrc, ALUBSrc, PCtoBL, IMen, fault}
    logic [23:0] obs;
    assign obs = {State, PCwr, DMwr, dm_req, RFwr, flag_wr, ALUop, EXTop, NPCop, Rw,
                  RbSrc, ALUBSrc, PCtoBL, IMen, fault};

    logic [23:0] exp_q[$];
    logic        rdy_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [23:0] pk(input logic [3:0] st, input logic [4:0] en,
                                       input logic [3:0] aluop, input logic [1:0] ext,
                                       input logic [1:0] npc, input logic [1:0] rw,
                                       input logic [4:0] misc);
        return {st, en, aluop, ext, npc, rw, misc};
    endfunction

    task automatic push(input logic [23:0] e, input logic rdy);
        exp_q.push_back(e);
        rdy_q.push_back(rdy);
    endtask

    task automatic p_fetch();
        push(pk(4'd0, 5'b10000, 4'h0, 2'b00, 2'b00, 2'b00, 5'b00010), 1'b0);
    endtask
    task automatic p_decode();
        push(pk(4'd1, 5'b00000, 4'h0, 2'b00, 2'b00, 2'b00, 5'b00000), 1'b0);
    endtask
    task automatic p_exec(input logic [3:0] aluop, input logic [1:0] ext,
                          input logic alub, input logic rbsrc, input logic fw);
        push(pk(4'd2, {4'b0000, fw}, aluop, ext, 2'b00, 2'b00, {rbsrc, alub, 3'b000}), 1'b0);
    endtask
    task automatic p_mem(input logic dmwr, input logic rdy);
        push(pk(4'd3, {1'b0, dmwr, 1'b1, 2'b00}, 4'h0, 2'b00, 2'b00, 2'b00, 5'b00000), rdy);
    endtask
    task automatic p_wb(input logic [1:0] rw);
        push(pk(4'd4, 5'b00010, 4'h0, 2'b00, 2'b00, rw, 5'b00000), 1'b0);
    endtask
    task automatic p_branch(input logic link);
        push(pk(4'd5, {1'b1, 2'b00, link, 1'b0}, 4'h0, 2'b10, 2'b01,
                link ? 2'b01 : 2'b00, {2'b00, link, 2'b00}), 1'b0);
    endtask
    task automatic p_mulx(input logic fw);
        push(pk(4'd6, {4'b0000, fw}, 4'h0, 2'b00, 2'b00, 2'b00, 5'b00000), 1'b0);
    endtask
    task automatic p_fault();
        push(pk(4'd7, 5'b00000, 4'h0, 2'b00, 2'b00, 2'b00, 5'b00001), 1'b0);
    endtask

    task automatic check(input string tag, input logic [23:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Entered just after a falling edge; leaves just after a falling edge.
    task automatic run(input string name, input logic [31:0] instr);
        int cyc = 0;
        instruction = instr;
        while (exp_q.size() > 0) begin
            logic [23:0] e;
            e        = exp_q.pop_front();
            dm_ready = rdy_q.pop_front();
            #1;
            check($sformatf("%s c%0d", name, cyc), e);
            cyc++;
            @(negedge clk);
        end
        dm_ready = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst      = 1'b1;
        dm_ready = 1'b0;
        #1;
        check({name, " rst_now"}, 24'h0);
        @(negedge clk);
        #1;
        check({name, " rst_held"}, 24'h0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("init");

        // LDR GT, ready on third MEM cycle
        p_fetch(); p_decode(); p_exec(4'b0100, 2'b00, 1'b1, 1'b1, 1'b0);
        p_mem(1'b0, 1'b0); p_mem(1'b0, 1'b0); p_mem(1'b0, 1'b1); p_wb(2'b00);
        run("ldr_gt", 32'hC5900AAA);

        // STR GT, U=0 so SUB, immediate ready
        p_fetch(); p_decode(); p_exec(4'b0010, 2'b00, 1'b1, 1'b1, 1'b0); p_mem(1'b1, 1'b1);
        run("str_gt", 32'hC5000875);

        p_fetch(); p_decode(); p_exec(4'b0100, 2'b01, 1'b0, 1'b0, 1'b1); p_wb(2'b00);
        run("adds_al", 32'hE0912003);

        p_fetch(); p_decode(); p_exec(4'b0100, 2'b01, 1'b1, 1'b0, 1'b0); p_wb(2'b00);
        run("add_imm", 32'hE2812005);

        p_fetch(); p_decode();
        run("addeqs_fail", 32'h00912003);

        Z = 1'b1;
        p_fetch(); p_decode(); p_exec(4'b0100, 2'b01, 1'b0, 1'b0, 1'b1); p_wb(2'b00);
        run("addeqs_pass", 32'h00912003);

        p_fetch(); p_decode();
        run("bne_fail", 32'h1A000004);

        Z = 1'b0;
        p_fetch(); p_decode(); p_exec(4'b1010, 2'b01, 1'b0, 1'b0, 1'b1);
        run("cmp", 32'hE1510002);

        p_fetch(); p_decode(); p_branch(1'b1);
        run("bl", 32'hEBFFFF00);

        N = 1'b1; V = 1'b1;
        p_fetch(); p_decode(); p_branch(1'b0);
        run("bge_pass", 32'hAA000002);
        p_fetch(); p_decode();
        run("blt_fail", 32'hBA000002);

        N = 1'b0; V = 1'b0; C = 1'b1;
        p_fetch(); p_decode(); p_branch(1'b0);
        run("bhi_pass", 32'h8A000001);
        p_fetch(); p_decode();
        run("bls_fail", 32'h9A000001);
        C = 1'b0;

        // Ready arrives in the very last MEM cycle before the timeout
        p_fetch(); p_decode(); p_exec(4'b0100, 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) p_mem(1'b0, 1'b0);
        p_mem(1'b0, 1'b1); p_wb(2'b00);
        run("ldr_late_ready", 32'hE5900000);

        p_fetch(); p_decode(); p_exec(4'b0100, 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) p_mem(1'b0, 1'b0);
        p_fault(); p_fault(); p_fault();
        run("ldr_timeout", 32'hE5900000);
        do_reset("after_timeout");
        p_fetch(); p_decode(); p_exec(4'b1010, 2'b01, 1'b0, 1'b0, 1'b1);
        run("cmp_after_timeout", 32'hE1510002);

        // Reset arriving in MEM aborts the load with nothing written
        p_fetch(); p_decode(); p_exec(4'b0100, 2'b00, 1'b1, 1'b1, 1'b0);
        run("ldr_abort", 32'hE5900000);
        do_reset("abort");
        p_fetch(); p_decode(); p_exec(4'b0100, 2'b00, 1'b1, 1'b1, 1'b0); p_mem(1'b1, 1'b1);
        run("str_after_abort", 32'hE5800000);

        p_fetch(); p_decode(); p_fault(); p_fault();
        run("cond_nv", 32'hF0912003);
        do_reset("cond_nv");
        p_fetch(); p_decode(); p_fault(); p_fault();
        run("undef_11", 32'hEE000000);
        do_reset("undef_11");
        p_fetch(); p_decode(); p_fault(); p_fault();
        run("undef_100", 32'hE8900000);
        do_reset("undef_100");
        p_fetch(); p_decode(); p_fault(); p_fault();
        run("ldr_regoff", 32'hE7900001);
        do_reset("ldr_regoff");

`ifdef CTRL_MUL_EN
        p_fetch(); p_decode(); p_exec(4'b0000, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MUL_CYCLES - 1; i++) p_mulx(1'b0);
        p_mulx(1'b1); p_wb(2'b10);
        run("muls", 32'hE0100291);
`else
        p_fetch(); p_decode(); p_fault(); p_fault();
        run("muls_undef", 32'hE0100291);
        do_reset("muls_undef");
`endif

        p_fetch(); p_decode(); p_exec(4'b0100, 2'b01, 1'b0, 1'b0, 1'b1); p_wb(2'b00);
        run("adds_final", 32'hE0912003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multi-cycle controller for the ARM-subset CPU core. It sequences each instruction through fetch, decode, execute, memory, write-back and branch states. It evaluates the full ARM condition field against the NZCV flags and drives every datapath enable and select. Unlike the previous controller, it handshakes with a variable-latency data memory, flags a memory timeout, traps undefined encodings, and optionally supports a multi-cycle MUL.

## Interface
Parameters:
- STATE_W, 4: width of the State output; must be ≥3.
- MEM_TIMEOUT, 16: number of consecutive MEM cycles without dm_ready before the controller faults (≥1).
- MUL_CYCLES, 4: number of MULX cycles (≥1); used only with CTRL_MUL_EN.

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: synchronous reset, active-high.
- instruction in 32: instruction word, valid during FETCH.
- N, Z, C, V in 1 each: architectural flags.
- dm_ready in 1: data memory completes the access this cycle.
- PCwr out 1: PC write enable.
- DMwr out 1: data memory write.
- dm_req out 1: data memory request.
- RFwr out 1: register file write enable.
- flag_wr out 1: NZCV update enable.
- ALUop out 4: ALU operation.
- EXTop out 2: extender mode. 00 = zero-extended imm12, 01 = rotated imm8, 10 = sign-extended imm24<<2.
- NPCop out 2: next-PC select. 00 = PC+4, 01 = branch target.
- Rw out 2: RF write-address select. 00 = [15:12], 01 = R14, 10 = [19:16].
- RbSrc out 1: RF read port B select. 0 = [3:0], 1 = [15:12].
- ALUBSrc out 1: ALU B input select. 0 = register, 1 = extended immediate.
- PCtoBL out 1: RF write data = PC+4.
- IMen out 1: instruction memory enable.
- fault out 1: sticky trap indicator.
- State out STATE_W: current state code.

## Operation
- States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, MULX=6, FAULT=7.
- FETCH:
  - Asserts IMen and PCwr with NPCop=00.
  - Captures instruction into ir.
  - Next state: DECODE.
- DECODE evaluates cond=ir[31:28] against NZCV, covering all 15 ARM conditions; 1111 is undefined.
  - Condition false → FETCH, with no write asserted.
  - Undefined encoding ([27:26]=11; [27:25]=100; [27:26]=01 with [25]=1; cond=1111) → FAULT.
  - Branch ([27:25]=101) → BRANCH.
  - Any other encoding → EXEC.
- EXEC, data-processing ([27:26]=00):
  - ALUop=ir[24:21]; ALUBSrc=ir[25]; EXTop=01.
  - flag_wr=ir[20].
  - Opcodes 10xx (TST/TEQ/CMP/CMN) → FETCH with flag_wr=1 and no RF write. All other opcodes → WB.
- EXEC, LDR/STR ([27:26]=01):
  - ALUop=0100 (ADD) if U=ir[23]=1, else 0010 (SUB).
  - ALUBSrc=1, EXTop=00, RbSrc=1.
  - Next state: MEM.
- MEM:
  - dm_req=1 every cycle; DMwr=~ir[20] every cycle.
  - On dm_ready: a load → WB; a store → FETCH.
- WB: RFwr=1 with Rw=00 (Rw=10 for MUL). Next state: FETCH.
- BRANCH:
  - PCwr=1, NPCop=01, EXTop=10.
  - If L=ir[24]=1, also RFwr=1, Rw=01, PCtoBL=1.
  - Next state: FETCH.
- FAULT: all enables 0, fault=1, IMen=0. The state is held until rst.
- Outputs are combinational from state and ir. Every output not listed for a state is 0.

## Timing
- While rst=1, every output is forced to 0. On the first clock edge with rst=1, the controller loads State=FETCH, clears ir, the wait counter, the MUL counter and fault.
- Cycle counts:
  - DP: 4 cycles; compare-type DP: 3.
  - STR: 4+w cycles; LDR: 5+w, where w is the number of MEM cycles before dm_ready.
  - B/BL: 3 cycles; condition-failed instruction: 2.
- The wait counter increments in each MEM cycle without dm_ready and clears on leaving MEM.
- If the counter reaches MEM_TIMEOUT-1 without dm_ready, the next state is FAULT.
- dm_ready in the same cycle as the timeout takes priority, and the access completes normally.
- dm_ready in the first MEM cycle gives a single-cycle MEM.
- rst mid-instruction aborts the instruction on that edge. No partial write is issued in the reset cycle.

## Configuration
- CTRL_MUL_EN defined:
  - MUL ([27:22]=000000, [7:4]=1001) goes EXEC→MULX.
  - MULX is held for exactly MUL_CYCLES cycles, then → WB with Rw=10; flag_wr=ir[20] in the final MULX cycle.
  - A MUL instruction takes 4+MUL_CYCLES cycles in total.
- CTRL_MUL_EN undefined: MUL encodings are decoded as undefined → FAULT, and state 6 is unreachable.

## Test plan
- LDR 0xC5900AAA with Z=0 (GT passes), dm_ready asserted on the 3rd MEM cycle → states 0,1,2,3,3,3,4,0; RFwr=1 only in WB; dm_req high for exactly 3 cycles.
- STR 0xC5000875 with dm_ready immediate → states 0,1,2,3,0; DMwr=1 for one cycle; RFwr never asserted.
- ADDS (ir[20]=1) with cond AL → flag_wr=1 in EXEC, RFwr=1 in WB. With cond EQ and Z=0 → DECODE→FETCH and no enables asserted.
- BL 0xEBFFFF00 → BRANCH with PCwr=1, NPCop=01, RFwr=1, Rw=01, PCtoBL=1; 3 cycles total.
- LDR with dm_ready held low, MEM_TIMEOUT=16 → FAULT after 16 MEM cycles; fault=1 sticky; rst pulse returns the controller to FETCH with fault=0.
- MUL with CTRL_MUL_EN, MUL_CYCLES=4 → 4 MULX cycles then WB with Rw=10. The same MUL without the macro → FAULT.
